// File: rtl/clk_phase_rst_ctrl.sv
// Clock-enable phase sequencer and reset conditioner. It debounces the reset button, stretches sys_rst
// and rotates one-hot phase enables on the single clock. Defining CLK_PHASE_STEP_EN adds single-step ports.
module clk_phase_rst_ctrl #(
    parameter int NUM_PHASES      = 3,
    parameter int DEBOUNCE_LEN    = 16,
    parameter int RST_HOLD_CYCLES = 4,
    parameter int CNT_W           = 32,
    // Derived from NUM_PHASES; leave at its default.
    parameter int PHASE_W         = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  btn_rst_n,
    input  logic                  hold,
`ifdef CLK_PHASE_STEP_EN
    input  logic                  step_mode,
    input  logic                  step_req,
`endif
    output logic                  sys_rst,
    output logic [NUM_PHASES-1:0] phase_en,
    output logic [PHASE_W-1:0]    phase_idx,
    output logic                  instr_start,
    output logic [CNT_W-1:0]      retired_cnt
);

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_HOLD  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam logic [7:0]         HOLD_LAST  = (RST_HOLD_CYCLES > 0) ? 8'(RST_HOLD_CYCLES - 1) : 8'd0;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(NUM_PHASES - 1);

    logic                    btn_sync1_reg, btn_sync2_reg;
    logic [DEBOUNCE_LEN-2:0] hist_reg;
    logic [DEBOUNCE_LEN-1:0] window;
    logic                    released_reg, released_next;
    logic [1:0]              state_reg, state_next;
    logic [7:0]              hold_cnt_reg, hold_cnt_next;
    logic [PHASE_W-1:0]      phase_idx_reg, phase_idx_next;
    logic [CNT_W-1:0]        retired_reg, retired_next;
    logic                    step_gate;
    logic                    run_gate;
    logic                    last_phase;

    // The newest synchronised sample plus DEBOUNCE_LEN-1 stored samples form the debounce window,
    // so the debounced state updates on the same edge the window fills.
    assign window = {hist_reg, btn_sync2_reg};

    always_comb begin
        released_next = released_reg;
        if (&window) begin
            released_next = 1'b1;
        end else if (~|window) begin
            released_next = 1'b0;
        end
    end

    always_comb begin
        state_next    = state_reg;
        hold_cnt_next = hold_cnt_reg;
        case (state_reg)
            ST_RESET: begin
                hold_cnt_next = 8'd0;
                if (released_reg) begin
                    state_next = (RST_HOLD_CYCLES == 0) ? ST_RUN : ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (hold_cnt_reg == HOLD_LAST) begin
                    state_next = ST_RUN;
                end else begin
                    hold_cnt_next = hold_cnt_reg + 8'd1;
                end
            end
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_RESET;
        endcase
        if (!released_reg) begin
            state_next = ST_RESET;
        end
    end

    assign sys_rst    = (state_reg != ST_RUN);
    assign run_gate   = ~sys_rst & ~hold & step_gate;
    assign last_phase = (phase_idx_reg == PHASE_LAST);

`ifdef CLK_PHASE_STEP_EN
    logic step_req_d_reg;
    logic step_active_reg, step_active_next;
    logic step_rise;

    assign step_rise = step_req & ~step_req_d_reg;
    assign step_gate = ~step_mode | step_active_reg;

    // A step request is accepted only while idle; it then lasts until the last phase has been enabled.
    always_comb begin
        step_active_next = step_active_reg;
        if (!step_mode || state_next != ST_RUN || sys_rst) begin
            step_active_next = 1'b0;
        end else if (step_active_reg) begin
            if (run_gate && last_phase) begin
                step_active_next = 1'b0;
            end
        end else if (step_rise) begin
            step_active_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_req_d_reg  <= 1'b0;
            step_active_reg <= 1'b0;
        end else begin
            step_req_d_reg  <= step_req;
            step_active_reg <= step_active_next;
        end
    end
`else
    assign step_gate = 1'b1;
`endif

    // Leaving RUN zeroes the phase and the count on the same edge, so no partial phase survives a reset.
    always_comb begin
        phase_idx_next = phase_idx_reg;
        retired_next   = retired_reg;
        if (state_next != ST_RUN) begin
            phase_idx_next = '0;
            retired_next   = '0;
        end else if (run_gate) begin
            phase_idx_next = last_phase ? '0 : phase_idx_reg + PHASE_W'(1);
            if (last_phase) begin
                retired_next = retired_reg + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_sync1_reg <= 1'b0;
            btn_sync2_reg <= 1'b0;
            hist_reg      <= '0;
            released_reg  <= 1'b0;
            state_reg     <= ST_RESET;
            hold_cnt_reg  <= 8'd0;
            phase_idx_reg <= '0;
            retired_reg   <= '0;
        end else begin
            btn_sync1_reg <= btn_rst_n;
            btn_sync2_reg <= btn_sync1_reg;
            hist_reg      <= window[DEBOUNCE_LEN-2:0];
            released_reg  <= released_next;
            state_reg     <= state_next;
            hold_cnt_reg  <= hold_cnt_next;
            phase_idx_reg <= phase_idx_next;
            retired_reg   <= retired_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_phase_en
            assign phase_en[gi] = run_gate & (phase_idx_reg == PHASE_W'(gi));
        end
    endgenerate

    assign instr_start = phase_en[0];
    assign phase_idx   = phase_idx_reg;
    assign retired_cnt = retired_reg;

endmodule

// File: tb/tb_clk_phase_rst_ctrl.sv
// Directed bench for clk_phase_rst_ctrl: a 3-phase instance and a 1-phase, 4-bit-counter instance,
// with expectations queued before each edge and checked after it.
module tb_clk_phase_rst_ctrl;

    logic        clk = 1'b0;
    logic        rst, btn, hold;
    logic        sys_rst, instr_start;
    logic [2:0]  phase_en;
    logic [1:0]  phase_idx;
    logic [31:0] retired_cnt;

    logic        rst_b, btn_b, hold_b;
    logic        sys_rst_b, instr_start_b;
    logic [0:0]  phase_en_b;
    logic [0:0]  phase_idx_b;
    logic [3:0]  retired_b;

`ifdef CLK_PHASE_STEP_EN
    logic step_mode, step_req;
`endif

    always #5 clk = ~clk;

    clk_phase_rst_ctrl #(
        .NUM_PHASES(3), .DEBOUNCE_LEN(4), .RST_HOLD_CYCLES(2), .CNT_W(32)
    ) u_dut (
        .clk(clk), .rst(rst), .btn_rst_n(btn), .hold(hold),
`ifdef CLK_PHASE_STEP_EN
        .step_mode(step_mode), .step_req(step_req),
`endif
        .sys_rst(sys_rst), .phase_en(phase_en), .phase_idx(phase_idx),
        .instr_start(instr_start), .retired_cnt(retired_cnt)
    );

    clk_phase_rst_ctrl #(
        .NUM_PHASES(1), .DEBOUNCE_LEN(4), .RST_HOLD_CYCLES(0), .CNT_W(4)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .btn_rst_n(btn_b), .hold(hold_b),
`ifdef CLK_PHASE_STEP_EN
        .step_mode(1'b0), .step_req(1'b0),
`endif
        .sys_rst(sys_rst_b), .phase_en(phase_en_b), .phase_idx(phase_idx_b),
        .instr_start(instr_start_b), .retired_cnt(retired_b)
    );

    typedef struct {
        string       tag;
        bit          unit_b;
        logic [38:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference state of the 3-phase instance
    bit   m_run = 1'b0;
    int   m_idx = 0;
    int   m_cnt = 0;
    int   mb_cnt = 0;

    function automatic logic [38:0] obs_a();
        return {sys_rst, instr_start, phase_en, phase_idx, retired_cnt};
    endfunction

    function automatic logic [38:0] obs_b();
        return {sys_rst_b, instr_start_b, 2'b00, phase_en_b, 1'b0, phase_idx_b, 28'd0, retired_b};
    endfunction

    task automatic push_a(input string tag, input logic sr, input logic [2:0] en,
                          input logic [1:0] idx, input logic [31:0] cnt);
        exp_t e;
        e.tag = tag; e.unit_b = 1'b0; e.val = {sr, en[0], en, idx, cnt};
        sb_q.push_back(e);
    endtask

    task automatic push_b(input string tag, input logic sr, input logic en, input logic [3:0] cnt);
        exp_t e;
        e.tag = tag; e.unit_b = 1'b1; e.val = {sr, en, 2'b00, en, 1'b0, 1'b0, 28'd0, cnt};
        sb_q.push_back(e);
    endtask

    task automatic check_next();
        exp_t        e;
        logic [38:0] o;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard_empty: observed=empty expected=entry");
        end else begin
            e = sb_q.pop_front();
            o = e.unit_b ? obs_b() : obs_a();
            total++;
            assert (o === e.val) else begin
                bad++;
                $error("FAIL %s: observed sr=%b en=%b idx=%0d cnt=%0d expected sr=%b en=%b idx=%0d cnt=%0d",
                       e.tag, o[38], o[36:34], o[33:32], o[31:0],
                       e.val[38], e.val[36:34], e.val[33:32], e.val[31:0]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2:0] exp_en();
        logic [2:0] one = 3'b001;
        return (m_run && !hold) ? (one << m_idx) : 3'b000;
    endfunction

    task automatic run_a(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            if (m_run && !hold) begin
                if (m_idx == 2) begin
                    m_idx = 0;
                    m_cnt++;
                end else begin
                    m_idx++;
                end
            end
            push_a(tag, !m_run, exp_en(), 2'(m_idx), 32'(m_cnt));
            tick();
            check_next();
        end
    endtask

    // Edge on which sys_rst is expected to fall (first RUN cycle shows phase 0)
    task automatic release_edge_a(input string tag);
        push_a(tag, 1'b0, 3'b001, 2'd0, 32'd0);
        tick();
        check_next();
        m_run = 1'b1; m_idx = 0; m_cnt = 0;
    endtask

    initial begin
        rst = 1'b1; btn = 1'b0; hold = 1'b0;
        rst_b = 1'b1; btn_b = 1'b0; hold_b = 1'b0;
`ifdef CLK_PHASE_STEP_EN
        step_mode = 1'b0; step_req = 1'b0;
`endif
        repeat (3) tick();
        push_a("reset_a", 1'b1, 3'b000, 2'd0, 32'd0);
        check_next();
        push_b("reset_b", 1'b1, 1'b0, 4'd0);
        check_next();

        rst = 1'b0; rst_b = 1'b0;
        run_a("pressed_idle", 3);

        // Release: 2 sync + 4 debounce + 1 FSM + 2 hold = 9 edges
        btn = 1'b1;
        run_a("release_wait", 8);
        release_edge_a("release_edge9");
        run_a("rotate", 4);

        // Stall while in phase 1
        hold = 1'b1;
        #1;
        push_a("hold_immediate", 1'b0, 3'b000, 2'd1, 32'd1);
        check_next();
        run_a("hold_frozen", 3);
        hold = 1'b0;
        #1;
        push_a("hold_resume", 1'b0, 3'b010, 2'd1, 32'd1);
        check_next();
        run_a("rotate_after_hold", 3);

        // Three-sample glitch must not disturb the rotation
        btn = 1'b0;
        run_a("bounce_low", 3);
        btn = 1'b1;
        run_a("bounce_high", 8);

        // Real press: sys_rst rises after 2 + 4 + 1 = 7 edges
        btn = 1'b0;
        run_a("press_wait", 6);
        push_a("press_edge7", 1'b1, 3'b000, 2'd0, 32'd0);
        tick();
        check_next();
        m_run = 1'b0; m_idx = 0; m_cnt = 0;

        btn = 1'b1;
        run_a("release2_wait", 8);
        release_edge_a("release2_edge9");
        run_a("rotate_to_p2", 2);

        // Asynchronous reset in the middle of phase 2
        rst = 1'b1;
        #1;
        push_a("async_rst", 1'b1, 3'b000, 2'd0, 32'd0);
        check_next();
        m_run = 1'b0; m_idx = 0; m_cnt = 0;
        run_a("async_rst_held", 2);
        rst = 1'b0;
        run_a("release3_wait", 8);
        release_edge_a("release3_edge9");

`ifdef CLK_PHASE_STEP_EN
        step_mode = 1'b1;
        #1;
        push_a("step_idle", 1'b0, 3'b000, 2'd0, 32'd0);
        check_next();
        push_a("step_idle_edge", 1'b0, 3'b000, 2'd0, 32'd0);
        tick();
        check_next();
        step_req = 1'b1;
        push_a("step_p0", 1'b0, 3'b001, 2'd0, 32'd0);
        tick();
        check_next();
        step_req = 1'b0;
        push_a("step_p1", 1'b0, 3'b010, 2'd1, 32'd0);
        tick();
        check_next();
        step_req = 1'b1;
        push_a("step_p2", 1'b0, 3'b100, 2'd2, 32'd0);
        tick();
        check_next();
        step_req = 1'b0;
        push_a("step_done", 1'b0, 3'b000, 2'd0, 32'd1);
        tick();
        check_next();
        push_a("step_stays_idle", 1'b0, 3'b000, 2'd0, 32'd1);
        tick();
        check_next();
`endif

        // Single-phase instance: no hold stretch, so release takes 7 edges
        btn_b = 1'b1;
        repeat (6) tick();
        push_b("b_release_wait", 1'b1, 1'b0, 4'd0);
        check_next();
        push_b("b_release_edge7", 1'b0, 1'b1, 4'd0);
        tick();
        check_next();
        mb_cnt = 0;
        for (int i = 0; i < 22; i++) begin
            hold_b = (i % 5 == 3);
            #1;
            push_b("b_run", 1'b0, !hold_b, 4'(mb_cnt));
            check_next();
            if (!hold_b) mb_cnt = (mb_cnt + 1) % 16;
            tick();
        end
        push_b("b_wrapped", 1'b0, !hold_b, 4'(mb_cnt));
        check_next();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
